// File: rtl/eth_parser_pkg.sv
// eth_parser_pkg: shared constants and types for the Ethernet parser stages
// ETH_HDR_LEN/ETH_HDR_W size the captured header; hdr_state_t is the capture FSM state.
package eth_parser_pkg;
  localparam int ETH_HDR_LEN = 14;
  localparam int ETH_HDR_W = 112;
  typedef enum logic {ST_HDR, ST_PAYLOAD} hdr_state_t;
endpackage

// File: rtl/eth_header_capture_if.sv
// eth_header_capture_if: 8-bit byte stream with last flag and valid/ready handshake
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface eth_header_capture_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_axis_reg_slice.sv
// eth_axis_reg_slice: single-entry registered byte+last output stage
// clk/rst_n: clock, async active-low reset; in_*: load side with in_ready = room
// available (empty or draining this cycle); m: registered output stream.
module eth_axis_reg_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  eth_header_capture_if.master m
);
  logic load;
  assign in_ready = !m.tvalid || m.tready;
  assign load = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.tvalid <= 1'b0;
      m.tdata <= 8'd0;
      m.tlast <= 1'b0;
    end else begin
      if (load) begin
        m.tdata <= in_data;
        m.tlast <= in_last;
      end
      m.tvalid <= load || (m.tvalid && !m.tready);
    end
  end
endmodule

// File: rtl/eth_header_capture.sv
// eth_header_capture: collects the 14-byte Ethernet header and forwards the payload
// clk/rst_n: clock, async active-low reset; s: inbound frame bytes; m: payload bytes;
// header_bytes/header_valid: packed header (byte k at [k*8 +: 8]) and update pulse;
// runt_err: frame ended inside the header; frame_cnt/runt_cnt: wrapping status counters.
module eth_header_capture
  import eth_parser_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_header_capture_if.slave  s,
  eth_header_capture_if.master m,
  output logic [ETH_HDR_W-1:0] header_bytes,
  output logic                 header_valid,
  output logic                 runt_err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     runt_cnt
);
  localparam logic [3:0] LAST_IDX = 4'(ETH_HDR_LEN - 1);
  hdr_state_t state, state_nxt;
  logic [3:0] idx;
  logic [ETH_HDR_W-9:0] shadow;
  logic slice_ready, pay_valid, hdr_acc, hdr_done, runt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == ST_HDR) state_nxt = (hdr_done && !s.tlast) ? ST_PAYLOAD : ST_HDR;
    else state_nxt = (pay_valid && slice_ready && s.tlast) ? ST_HDR : ST_PAYLOAD;
  end
  // Header bytes are always accepted; a leftover payload byte may drain meanwhile.
  always_comb begin
    s.tready = (state == ST_HDR) || slice_ready;
    pay_valid = (state == ST_PAYLOAD) && s.tvalid;
    hdr_acc = (state == ST_HDR) && s.tvalid;
    hdr_done = hdr_acc && (idx == LAST_IDX);
    runt = hdr_acc && s.tlast && (idx != LAST_IDX);
  end
  // Byte 13 bypasses the shadow so the header publishes as one atomic update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 4'd0;
      shadow <= '0;
      header_bytes <= '0;
      header_valid <= 1'b0;
      runt_err <= 1'b0;
      frame_cnt <= '0;
      runt_cnt <= '0;
    end else begin
      header_valid <= hdr_done;
      runt_err <= runt;
      if (hdr_acc) idx <= (hdr_done || s.tlast) ? 4'd0 : idx + 4'd1;
      if (hdr_acc && !hdr_done) shadow[{idx, 3'b000} +: 8] <= s.tdata;
      if (hdr_done) begin
        header_bytes <= {s.tdata, shadow};
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (runt) runt_cnt <= runt_cnt + CNT_W'(1);
    end
  end
  eth_axis_reg_slice u_slice (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(s.tdata),
    .in_last(s.tlast),
    .in_valid(pay_valid),
    .in_ready(slice_ready),
    .m(m)
  );
endmodule

// File: tb/tb_eth_header_capture.sv
// tb_eth_header_capture: randomized scoreboard bench for eth_header_capture
module tb_eth_header_capture;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  eth_header_capture_if s_if ();
  eth_header_capture_if m_if ();
  logic [111:0] header_bytes;
  logic header_valid, runt_err;
  logic [CNT_W-1:0] frame_cnt, runt_cnt;
  eth_header_capture #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s_if),
    .m(m_if),
    .header_bytes(header_bytes),
    .header_valid(header_valid),
    .runt_err(runt_err),
    .frame_cnt(frame_cnt),
    .runt_cnt(runt_cnt)
  );
  int checks = 0, errors = 0;
  logic [8:0] exp_pay[$];
  logic [111:0] exp_hdr[$];
  int exp_fc[$];
  int exp_rc[$];
  int n_frames = 0, n_runts = 0;
  logic [111:0] last_hdr = '0;
  int tready_mode = 0, tr_phase = 0;
  bit in_pay = 0;
  bit prev_stall = 0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=output_present required=none_expected", name);
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tready_mode == 0) m_if.tready = 1'b1;
      else if (tready_mode == 1) m_if.tready = 1'($urandom % 2);
      else begin
        m_if.tready = (tr_phase % 4 == 0) || (tr_phase % 4 == 3);
        tr_phase++;
      end
    end
  end

  always @(negedge clk) begin : mon
    logic [111:0] h;
    if (rst_n) begin
      if (header_valid && runt_err) chk("pulse_overlap", 1, 0);
      if (m_if.tvalid && prev_stall) chk("stall_stable", {m_if.tlast, m_if.tdata}, prev_out);
      if (in_pay && m_if.tvalid && !m_if.tready) chk("s_tready_stall", s_if.tready, 0);
      if (m_if.tvalid && m_if.tready) begin
        if (exp_pay.size() == 0) fail_line("unexpected_payload");
        else chk("payload", {m_if.tlast, m_if.tdata}, exp_pay.pop_front());
      end
      if (header_valid) begin
        if (exp_hdr.size() == 0) fail_line("unexpected_header");
        else begin
          h = exp_hdr.pop_front();
          chk("header", header_bytes, h);
          chk("frame_cnt", frame_cnt, exp_fc.pop_front());
          last_hdr = h;
        end
      end else chk("header_hold", header_bytes, last_hdr);
      if (runt_err) begin
        if (exp_rc.size() == 0) fail_line("unexpected_runt");
        else chk("runt_cnt", runt_cnt, exp_rc.pop_front());
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_out = {m_if.tlast, m_if.tdata};
    end else prev_stall = 0;
  end

  task automatic send_frame(input int len, input bit pattern, input int stop_at, input int gap);
    logic [7:0] b[$];
    logic [111:0] h;
    int t;
    for (int i = 0; i < len; i++) b.push_back(pattern ? 8'(i) : 8'($urandom));
    if (len < 14) begin
      n_runts++;
      exp_rc.push_back(n_runts % 16);
    end else begin
      h = '0;
      for (int i = 0; i < 14; i++) h[i*8 +: 8] = b[i];
      exp_hdr.push_back(h);
      n_frames++;
      exp_fc.push_back(n_frames % 16);
      for (int i = 14; i < len; i++) exp_pay.push_back({i == len - 1, b[i]});
    end
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) break;
      while ($urandom_range(99) < gap) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata = b[i];
      s_if.tlast = (i == len - 1);
      in_pay = (i >= 14);
      t = 0;
      do begin
        @(negedge clk);
        t++;
        if (t > 2000) begin
          errors++;
          $display("FAIL s_handshake_timeout actual=no_ready required=ready");
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1);
        end
      end while (!s_if.tready);
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    in_pay = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0 || exp_rc.size() != 0 || m_if.tvalid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", t >= 1000, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_header", header_bytes, 0);
    chk("rst_hv", header_valid, 0);
    chk("rst_runt", runt_err, 0);
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_mdata", {m_if.tlast, m_if.tdata}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_rcnt", runt_cnt, 0);
    chk("rst_sready", s_if.tready, 1);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = 8'd0;
    s_if.tlast = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(60, 1, -1, 0);
    wait_idle();
    chk("t1_hdr_lo", header_bytes[47:0], 48'h050403020100);
    chk("t1_hdr_hi", header_bytes[111:96], 16'h0D0C);
    chk("t1_fcnt", frame_cnt, 1);
    send_frame(9, 1, -1, 0);
    send_frame(20, 0, -1, 0);
    wait_idle();
    chk("t2_rcnt", runt_cnt, 1);
    chk("t2_fcnt", frame_cnt, 2);
    send_frame(14, 0, -1, 0);
    @(negedge clk);
    chk("hdr_only_ready", s_if.tready, 1);
    @(posedge clk);
    #1;
    send_frame(20, 0, -1, 0);
    wait_idle();
    tr_phase = 0;
    tready_mode = 2;
    send_frame(40, 0, -1, 0);
    wait_idle();
    tready_mode = 0;
    send_frame(30, 1, 19, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_pay.delete();
    exp_hdr.delete();
    exp_fc.delete();
    exp_rc.delete();
    n_frames = 0;
    n_runts = 0;
    last_hdr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(20, 1, -1, 0);
    wait_idle();
    chk("post_rst_hdr_lo", header_bytes[47:0], 48'h050403020100);
    for (int i = 0; i < 16; i++) send_frame($urandom_range(14, 30), 0, -1, 10);
    wait_idle();
    chk("wrap17", frame_cnt, 1);
    tready_mode = 1;
    for (int i = 0; i < 25; i++) send_frame($urandom_range(1, 40), 0, -1, 20);
    wait_idle();
    chk("final_fcnt", frame_cnt, n_frames % 16);
    chk("final_rcnt", runt_cnt, n_runts % 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_header_capture.md
# eth_header_capture

Byte-stream front end of the Ethernet parser. Accepts a frame as an 8-bit valid/ready stream, collects the first 14 bytes into the packed header vector consumed by `eth_header_parser`, and forwards the remaining payload bytes through a one-entry registered output. Frames too short to carry a full header are flagged and dropped. Per-frame counters are provided for status.

## Interface

Parameters:
- `CNT_W`, default 16: width of the frame and runt counters.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `s_tdata`, input, 8: inbound frame byte.
- `s_tvalid`, input, 1: inbound byte valid.
- `s_tlast`, input, 1: inbound byte is the last byte of the frame.
- `s_tready`, output, 1: block accepts the inbound byte.
- `header_bytes`, output, 112: packed header. Byte k of the frame sits at bits [k*8 +: 8].
- `header_valid`, output, 1: one-cycle pulse when `header_bytes` is updated.
- `m_tdata`, output, 8: payload byte.
- `m_tvalid`, output, 1: payload byte valid.
- `m_tlast`, output, 1: last payload byte of the frame.
- `m_tready`, input, 1: downstream accepts the payload byte.
- `runt_err`, output, 1: one-cycle pulse when a frame ends before byte 13.
- `frame_cnt`, output, `CNT_W`: count of headers completed. Wraps modulo 2^CNT_W.
- `runt_cnt`, output, `CNT_W`: count of runt frames. Wraps modulo 2^CNT_W.

## Operation

- A handshake occurs when `s_tvalid && s_tready` (inbound) or `m_tvalid && m_tready` (outbound).
- The FSM has two states.
- **ST_HDR** (reset state):
  - `s_tready`=1 unconditionally.
  - Each accepted byte is written to shadow[idx*8 +: 8]. `idx` is a 4-bit counter running 0..13.
  - Accepted byte with `s_tlast`=1 and idx<13: pulse `runt_err`, increment `runt_cnt`, set idx to 0, stay in ST_HDR. `header_bytes` is unchanged.
  - Accepted byte with idx==13:
    - Load `header_bytes` with {s_tdata, shadow[103:0]}.
    - Pulse `header_valid` and increment `frame_cnt`.
    - Set idx to 0.
    - If `s_tlast`=1, stay in ST_HDR (header-only frame; no payload is emitted). Otherwise go to ST_PAYLOAD.
- **ST_PAYLOAD**:
  - `s_tready` = !m_tvalid || m_tready.
  - Each accepted byte loads {m_tdata, m_tlast} and sets `m_tvalid`.
  - An accepted byte with `s_tlast`=1 returns the FSM to ST_HDR.
- Output register:
  - `m_tvalid` clears on an outbound handshake with no simultaneous load.
  - A simultaneous drain and load keeps `m_tvalid`=1 with the new byte.
  - `m_tdata` and `m_tlast` are stable while `m_tvalid && !m_tready`.
- `header_bytes` holds its value until the next header completes. It never shows a partially captured header.
- While in ST_HDR, a pending payload byte (the previous frame's last byte) may still drain. Header capture does not wait for it.
- `s_tvalid` low: no state change. Gaps inside a frame are allowed anywhere.

## Timing

- Reset values: state=ST_HDR, idx=0, shadow=0, `header_bytes`=0, `header_valid`=0, `runt_err`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `frame_cnt`=0, `runt_cnt`=0. `s_tready` is 1 (combinational from ST_HDR).
- `header_valid` and the new `header_bytes` appear together in the cycle after the handshake of byte 13. The new counter value appears in the same cycle.
- Payload latency: a byte accepted in cycle n drives `m_tdata` in cycle n+1.
- Throughput: 1 byte/cycle with `m_tready` held at 1.
- Back-to-back frames: byte 0 of the next frame is accepted in the cycle after the previous `s_tlast` handshake, with no bubble.
- Reset mid-frame:
  - All state clears immediately (asynchronous). A pending payload byte is lost.
  - The block treats the next accepted byte as byte 0. Frame realignment after reset is the upstream's responsibility.
- `runt_err` and `header_valid` never pulse in the same cycle.

## Structure

- Add to `eth_parser_pkg`:
  - `ETH_HDR_LEN` = 14.
  - `ETH_HDR_W` = 112.
  - `hdr_state_t` enum {ST_HDR, ST_PAYLOAD}.
- One sub-module, `eth_axis_reg_slice`: the 8-bit+last single-entry output register with ready passthrough. Reusable by later parser stages.
- FSM, index counter, shadow, and status counters live in the top module.

## Test plan

- **Single 60-byte frame**, byte k = k, `m_tready`=1:
  - `header_valid` pulses once; `header_bytes`[47:0]=0x050403020100, [111:96]=0x0D0C.
  - 46 payload bytes 0x0E..0x3B, with `m_tlast` on 0x3B.
  - `frame_cnt`=1.
- **Runt of 9 bytes** (tlast on byte 8) followed by a valid 20-byte frame:
  - `runt_err` pulses once; `runt_cnt`=1.
  - Second frame yields `header_valid` with correct bytes and 6 payload bytes.
  - `header_bytes` is unchanged during the runt.
- **Exactly 14-byte frame**: `header_valid` pulses, no `m_tvalid` ever, next frame's byte 0 accepted the following cycle.
- **Backpressure**, `m_tready` toggling 1,0,0,1 during payload:
  - `s_tready` drops while the register is full and unread.
  - No byte is lost or duplicated; `m_tdata` is stable while stalled.
- **Reset asserted at byte 5 of the payload**:
  - All outputs reach reset values immediately.
  - The next 20-byte frame parses correctly from byte 0.
- **Counter wrap**, `CNT_W`=4: 17 valid frames -> `frame_cnt`=1.
